bounce_generator: RTL and testbench

//  Produces an active-low, deliberately bouncy push-button waveform on command, the

---
 rtl/bounce_generator.sv | 141 ++++++++++++++
 tb/tb_bounce_generator.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_generator.sv
// Generates an active-low push-button waveform with LFSR-timed glitches on each edge,
// used to exercise the button debouncer. The sequence is fully repeatable for a given seed.
module bounce_generator #(
    parameter int          BOUNCE_PULSES = 2,
    parameter int          GAP_BITS      = 2,
    parameter int          HOLD_W        = 8,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [HOLD_W-1:0] hold_len,
    output logic              out,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W    = (HOLD_W > GAP_BITS) ? HOLD_W : GAP_BITS;
    localparam int SEG_W    = (BOUNCE_PULSES > 0) ? $clog2(2 * BOUNCE_PULSES) + 1 : 1;
    localparam int LAST_SEG = (BOUNCE_PULSES > 0) ? 2 * BOUNCE_PULSES - 1 : 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state_reg;
    logic              out_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [7:0]        lfsr_reg;
    logic [7:0]        lfsr_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [SEG_W-1:0]  seg_reg;
    logic [HOLD_W-1:0] hold_reg;
    logic [CNT_W-1:0]  gap_m1;

    // Fibonacci LFSR: shift left, feedback taps 7,5,4,3 enter at bit 0.
    assign lfsr_next[0] = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
    genvar gi;
    generate
        for (gi = 1; gi < 8; gi++) begin : g_shift
            assign lfsr_next[gi] = lfsr_reg[gi-1];
        end
    endgenerate

    // Counters hold (length - 1); a gap of lfsr[GAP_BITS-1:0]+1 cycles loads the raw bits.
    assign gap_m1 = CNT_W'(lfsr_reg[GAP_BITS-1:0]);

    function automatic logic [CNT_W-1:0] hold_m1(input logic [HOLD_W-1:0] h);
        return (h == '0) ? '0 : CNT_W'(h - HOLD_W'(1));
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            out_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            lfsr_reg  <= LFSR_SEED;
            cnt_reg   <= '0;
            seg_reg   <= '0;
            hold_reg  <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        busy_reg <= 1'b1;
                        out_reg  <= 1'b0;
                        hold_reg <= hold_len;
                        if (BOUNCE_PULSES > 0) begin
                            state_reg <= PRESS;
                            cnt_reg   <= gap_m1;
                            lfsr_reg  <= lfsr_next;
                            seg_reg   <= '0;
                        end else begin
                            state_reg <= HOLD;
                            cnt_reg   <= hold_m1(hold_len);
                        end
                    end
                end
                PRESS: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end else begin
                        out_reg <= ~out_reg;
                        if (seg_reg == SEG_W'(LAST_SEG)) begin
                            state_reg <= HOLD;
                            cnt_reg   <= hold_m1(hold_reg);
                        end else begin
                            seg_reg  <= seg_reg + SEG_W'(1);
                            cnt_reg  <= gap_m1;
                            lfsr_reg <= lfsr_next;
                        end
                    end
                end
                HOLD: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end else if (BOUNCE_PULSES > 0) begin
                        out_reg   <= 1'b1;
                        state_reg <= RELEASE;
                        seg_reg   <= '0;
                        cnt_reg   <= gap_m1;
                        lfsr_reg  <= lfsr_next;
                    end else begin
                        out_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                RELEASE: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end else if (seg_reg == SEG_W'(LAST_SEG)) begin
                        // Last release segment is always low, so ending returns out high.
                        out_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        out_reg  <= ~out_reg;
                        seg_reg  <= seg_reg + SEG_W'(1);
                        cnt_reg  <= gap_m1;
                        lfsr_reg <= lfsr_next;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out  = out_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_bounce_generator.sv
// Scoreboard bench for bounce_generator: three configurations driven with random starts,
// expected segments produced by a segment-level reference model and checked by a monitor.
module tb_bounce_generator;

    localparam int N = 3;
    localparam int BP_OF [N] = '{2, 0, 2};
    localparam int GB_OF [N] = '{2, 2, 1};

    typedef struct packed {
        logic        lvl;
        logic [15:0] len;
    } seg_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       start_v [N];
    logic [7:0] hold_v  [N];
    logic       out_w   [N];
    logic       busy_w  [N];
    logic       done_w  [N];

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    int         edge_n = 0;
    logic [7:0] m_lfsr     [N];
    int         acc_edge   [N];
    int         last_end   [N];
    int         hold_start [N];
    int         accepted   [N];
    logic       busy_exp   [N];
    logic       done_exp   [N];
    seg_t       seg_q      [N][$];

    // monitor state
    logic in_seg  [N];
    logic cur_lvl [N];
    int   cur_len [N];
    int   tog     [N];

    // bench-side debouncer on instance 2
    logic db_lvl = 1'b1;
    int   db_cnt = 0;
    int   falls  = 0;

    always #5 clk = ~clk;

    bounce_generator #(.BOUNCE_PULSES(2), .GAP_BITS(2), .HOLD_W(8), .LFSR_SEED(8'hA5)) u0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .hold_len(hold_v[0]),
        .out(out_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    bounce_generator #(.BOUNCE_PULSES(0), .GAP_BITS(2), .HOLD_W(8), .LFSR_SEED(8'hA5)) u1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .hold_len(hold_v[1]),
        .out(out_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    bounce_generator #(.BOUNCE_PULSES(2), .GAP_BITS(1), .HOLD_W(8), .LFSR_SEED(8'hA5)) u2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .hold_len(hold_v[2]),
        .out(out_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    task automatic chk(input string name, input int d, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s dut%0d @%0t: got %0d want %0d", name, d, $time, act, exp);
        end
    endtask

    // Reference model: on acceptance, expand the whole sequence into (level, length) segments.
    initial begin
        for (int d = 0; d < N; d++) begin
            m_lfsr[d] = 8'hA5; acc_edge[d] = 0; last_end[d] = -1; hold_start[d] = 0;
            accepted[d] = 0; busy_exp[d] = 1'b0; done_exp[d] = 1'b0;
        end
        forever begin
            @(posedge clk);
            edge_n++;
            for (int d = 0; d < N; d++) begin
                if (!reset) begin
                    m_lfsr[d] = 8'hA5; last_end[d] = -1; acc_edge[d] = 0;
                    busy_exp[d] = 1'b0; done_exp[d] = 1'b0;
                    seg_q[d].delete();
                end else begin
                    done_exp[d] = (edge_n == last_end[d]);
                    if (start_v[d] && edge_n > last_end[d]) begin
                        int   total;
                        int   len;
                        seg_t s;
                        total = 0;
                        for (int i = 0; i < 2 * BP_OF[d]; i++) begin
                            len = int'(m_lfsr[d] & 8'((1 << GB_OF[d]) - 1)) + 1;
                            s.lvl = (i % 2 == 1); s.len = 16'(len);
                            seg_q[d].push_back(s);
                            total += len;
                            m_lfsr[d] = lfsr_step(m_lfsr[d]);
                        end
                        hold_start[d] = edge_n + total;
                        len = (hold_v[d] == 8'd0) ? 1 : int'(hold_v[d]);
                        s.lvl = 1'b0; s.len = 16'(len);
                        seg_q[d].push_back(s);
                        total += len;
                        for (int i = 0; i < 2 * BP_OF[d]; i++) begin
                            len = int'(m_lfsr[d] & 8'((1 << GB_OF[d]) - 1)) + 1;
                            s.lvl = (i % 2 == 0); s.len = 16'(len);
                            seg_q[d].push_back(s);
                            total += len;
                            m_lfsr[d] = lfsr_step(m_lfsr[d]);
                        end
                        acc_edge[d] = edge_n;
                        last_end[d] = edge_n + total;
                        accepted[d]++;
                    end
                    busy_exp[d] = (edge_n >= acc_edge[d]) && (edge_n < last_end[d]);
                end
            end
        end
    end

    task automatic close_seg(input int d);
        seg_t e;
        vectors++;
        if (seg_q[d].size() == 0) begin
            miscompares++;
            $display("FAIL seg_extra dut%0d @%0t: got segment lvl %0d len %0d, want none",
                     d, $time, cur_lvl[d], cur_len[d]);
        end else begin
            e = seg_q[d].pop_front();
            if (cur_lvl[d] != e.lvl || cur_len[d] != int'(e.len)) begin
                miscompares++;
                $display("FAIL segment dut%0d @%0t: got lvl %0d len %0d want lvl %0d len %0d",
                         d, $time, cur_lvl[d], cur_len[d], e.lvl, e.len);
            end
        end
    endtask

    // Monitor: measures out segments while busy and checks busy/done/idle level every cycle.
    initial begin
        for (int d = 0; d < N; d++) begin
            in_seg[d] = 1'b0; cur_lvl[d] = 1'b1; cur_len[d] = 0; tog[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < N; d++) begin
                if (!reset) begin
                    in_seg[d] = 1'b0;
                end else begin
                    chk("busy", d, int'(busy_w[d]), int'(busy_exp[d]));
                    chk("done", d, int'(done_w[d]), int'(done_exp[d]));
                    if (!busy_w[d]) chk("idle_out", d, int'(out_w[d]), 1);
                    if (busy_w[d]) begin
                        if (!in_seg[d]) begin
                            in_seg[d] = 1'b1; cur_lvl[d] = out_w[d]; cur_len[d] = 1; tog[d] = 0;
                        end else if (out_w[d] == cur_lvl[d]) begin
                            cur_len[d]++;
                        end else begin
                            close_seg(d);
                            cur_lvl[d] = out_w[d]; cur_len[d] = 1; tog[d]++;
                        end
                    end else if (in_seg[d]) begin
                        close_seg(d);
                        if (out_w[d] != cur_lvl[d]) tog[d]++;
                        chk("toggles_after_start", d, tog[d], 4 * BP_OF[d] + 1);
                        in_seg[d] = 1'b0;
                    end
                end
            end
        end
    end

    // Debouncer: level follows out after 4 consecutive differing samples.
    initial begin
        forever begin
            @(negedge clk);
            if (out_w[2] == db_lvl) begin
                db_cnt = 0;
            end else begin
                db_cnt++;
                if (db_cnt >= 4) begin
                    db_lvl = out_w[2];
                    db_cnt = 0;
                    if (!db_lvl) falls++;
                end
            end
        end
    end

    task automatic pulse(input int d, input logic [7:0] h);
        @(negedge clk);
        start_v[d] = 1'b1;
        hold_v[d]  = h;
        @(negedge clk);
        start_v[d] = 1'b0;
        hold_v[d]  = 8'($urandom);
    endtask

    task automatic wait_idle(input int d);
        int k;
        k = 0;
        while (edge_n <= last_end[d] + 1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) begin
            vectors++; miscompares++;
            $display("FAIL wait_idle dut%0d: still busy after %0d cycles, want idle", d, k);
        end
    endtask

    initial begin
        int k;
        int n0;
        int f0;
        for (int d = 0; d < N; d++) begin
            start_v[d] = 1'b0; hold_v[d] = 8'd0;
        end
        // reset asserted with start high
        #2;
        reset = 1'b0;
        for (int d = 0; d < N; d++) start_v[d] = 1'b1;
        #20;
        for (int d = 0; d < N; d++) begin
            chk("reset_out", d, int'(out_w[d]), 1);
            chk("reset_busy", d, int'(busy_w[d]), 0);
            chk("reset_done", d, int'(done_w[d]), 0);
        end
        @(negedge clk); #1;
        for (int d = 0; d < N; d++) start_v[d] = 1'b0;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        for (int d = 0; d < N; d++) chk("post_reset_out", d, int'(out_w[d]), 1);

        // clean edges, including hold_len = 0
        pulse(1, 8'd5);  wait_idle(1);
        pulse(1, 8'd0);  wait_idle(1);

        // seeded gaps and edge count with hold 10
        pulse(0, 8'd10); wait_idle(0);

        // start held across busy and done: ignored while busy, then back-to-back
        n0 = accepted[0];
        @(negedge clk);
        start_v[0] = 1'b1; hold_v[0] = 8'd6;
        k = 0;
        while (accepted[0] < n0 + 2 && k < 500) begin
            @(negedge clk);
            hold_v[0] = 8'($urandom_range(0, 15));
            k++;
        end
        start_v[0] = 1'b0;
        chk("back_to_back_accepts", 0, accepted[0] - n0, 2);
        wait_idle(0);

        // random traffic across all three instances
        repeat (30) begin
            int d;
            d = $urandom_range(0, N - 1);
            pulse(d, 8'($urandom_range(0, 12)));
            k = $urandom_range(0, 6);
            repeat (k) begin
                @(negedge clk);
                start_v[d] = 1'($urandom_range(0, 1));
                hold_v[d]  = 8'($urandom);
            end
            start_v[d] = 1'b0;
            if ($urandom_range(0, 1) == 1) wait_idle(d);
        end
        for (int d = 0; d < N; d++) wait_idle(d);

        // abort in the middle of HOLD
        pulse(0, 8'd30);
        k = 0;
        while (edge_n < hold_start[0] + 5 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("abort_busy_before", 0, int'(busy_w[0]), 1);
        #1 reset = 1'b0;
        #1;
        chk("abort_out", 0, int'(out_w[0]), 1);
        chk("abort_busy", 0, int'(busy_w[0]), 0);
        chk("abort_done", 0, int'(done_w[0]), 0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_abort_out", 0, int'(out_w[0]), 1);

        // debouncer loop: each long press must produce exactly one falling output
        repeat (6) @(negedge clk);
        f0 = falls;
        repeat (3) begin
            pulse(2, 8'd20);
            wait_idle(2);
            repeat (6) @(negedge clk);
        end
        chk("debounce_falls", 2, falls - f0, 3);
        chk("debounce_final", 2, int'(db_lvl), 1);

        for (int d = 0; d < N; d++) chk("leftover_segments", d, seg_q[d].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
